// File: rtl/eeprom_pkg.sv
// eeprom_pkg: shared definitions for the serial EEPROM responder.
//   - ADDR_W_DEF / DEV_CODE_DEF : default array depth and device-type nibble
//   - ACK / NACK                : bus levels of the acknowledge slot
//   - state_t                   : byte-level protocol states of eeprom_slave
package eeprom_pkg;

    localparam int         ADDR_W_DEF   = 11;
    localparam logic [3:0] DEV_CODE_DEF = 4'b1010;

    localparam logic ACK  = 1'b0;
    localparam logic NACK = 1'b1;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CTRL,
        ST_CTRL_ACK,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_WDATA,
        ST_WDATA_ACK,
        ST_RDATA,
        ST_RDATA_ACK
    } state_t;

endpackage

// File: rtl/eeprom_line_sync.sv
// eeprom_line_sync: brings SCL/SDA into the system clock domain and decodes
// bus events.
//   clk, rst_n          : system clock, synchronous active-low reset
//   scl, sda            : raw bus lines
//   sda_s               : synchronized SDA level
//   scl_rise, scl_fall  : one-clk SCL edge strobes
//   start_det, stop_det : one-clk START / STOP strobes
module eeprom_line_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic scl,
    input  logic sda,
    output logic sda_s,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);

    // [0],[1] form the synchronizer, [2] is the previous synchronized value.
    logic [2:0] scl_q, scl_d;
    logic [2:0] sda_q, sda_d;

    always_comb begin
        scl_d = {scl_q[1:0], scl};
        sda_d = {sda_q[1:0], sda};
    end

    // Reset to the idle bus level so leaving reset never fakes a START.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            scl_q <= '1;
            sda_q <= '1;
        end else begin
            scl_q <= scl_d;
            sda_q <= sda_d;
        end
    end

    assign sda_s    = sda_q[1];
    assign scl_rise = scl_q[1] & ~scl_q[2];
    assign scl_fall = ~scl_q[1] & scl_q[2];
    // SCL must be high in both samples: an SDA change that lands in the same
    // clk as an SCL change is treated as data, not as START/STOP.
    assign start_det = scl_q[1] & scl_q[2] & ~sda_q[1] & sda_q[2];
    assign stop_det  = scl_q[1] & scl_q[2] & sda_q[1] & ~sda_q[2];

endmodule

// File: rtl/eeprom_slave.sv
// eeprom_slave: two-wire serial EEPROM responder with a 2^ADDR_W x 8 array.
//   CLK       : system clock (>= 8x SCL)
//   RESET     : synchronous active-low reset
//   SCL       : bus clock from the master
//   SDA       : open-drain data line, only ever pulled low or released
//   BUSY      : high from a valid START until STOP / abort
//   WR_PULSE  : one-clk strobe per byte committed to the array
//   WR_ADDR   : address of the last committed byte
//   dbg_state : current protocol state
module eeprom_slave
    import eeprom_pkg::*;
#(
    parameter int         ADDR_W   = ADDR_W_DEF,
    parameter logic [3:0] DEV_CODE = DEV_CODE_DEF
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              SCL,
    inout  wire               SDA,
    output logic              BUSY,
    output logic              WR_PULSE,
    output logic [ADDR_W-1:0] WR_ADDR,
    output state_t            dbg_state
);

    logic sda_s, scl_rise, scl_fall, start_det, stop_det;

    eeprom_line_sync u_sync (
        .clk       (CLK),
        .rst_n     (RESET),
        .scl       (SCL),
        .sda       (SDA),
        .sda_s     (sda_s),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det)
    );

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [7:0]        shift_q, shift_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              sda_low_q, sda_low_d;
    logic              busy_q, busy_d;
    logic              wr_pulse_q, wr_pulse_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic              mem_we;
    logic [7:0]        rd_byte;

    logic [7:0] mem_q [0:(1<<ADDR_W)-1];

    assign rd_byte = mem_q[ptr_q];

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        ptr_d      = ptr_q;
        sda_low_d  = sda_low_q;
        wr_pulse_d = 1'b0;
        wr_addr_d  = wr_addr_q;
        mem_we     = 1'b0;

        if (stop_det) begin
            // Any partial byte is simply dropped.
            state_d   = ST_IDLE;
            sda_low_d = 1'b0;
        end else if (start_det) begin
            // Repeated START keeps the pointer for random reads.
            state_d   = ST_CTRL;
            cnt_d     = 4'd0;
            sda_low_d = 1'b0;
        end else begin
            case (state_q)
                ST_CTRL, ST_ADDR, ST_WDATA: begin
                    if (scl_rise && cnt_q != 4'd8) begin
                        shift_d = {shift_q[6:0], sda_s};
                        cnt_d   = cnt_q + 4'd1;
                    end else if (scl_fall && cnt_q == 4'd8) begin
                        cnt_d     = 4'd0;
                        sda_low_d = 1'b1;
                        if (state_q == ST_CTRL) begin
                            if (shift_q[7:4] != DEV_CODE) begin
                                state_d   = ST_IDLE;
                                sda_low_d = 1'b0;
                            end else begin
                                state_d = ST_CTRL_ACK;
                                // A read control byte's page bits are ignored.
                                if (!shift_q[0])
                                    ptr_d[ADDR_W-1:8] = shift_q[ADDR_W-8:1];
                            end
                        end else if (state_q == ST_ADDR) begin
                            state_d    = ST_ADDR_ACK;
                            ptr_d[7:0] = shift_q;
                        end else begin
                            state_d    = ST_WDATA_ACK;
                            mem_we     = 1'b1;
                            wr_pulse_d = 1'b1;
                            wr_addr_d  = ptr_q;
                            ptr_d      = ptr_q + 1'b1;
                        end
                    end
                end
                ST_CTRL_ACK, ST_ADDR_ACK, ST_WDATA_ACK: begin
                    if (scl_fall) begin
                        cnt_d     = 4'd0;
                        sda_low_d = 1'b0;
                        // shift_q still holds the control byte here, so bit 0 is R/W.
                        if (state_q == ST_CTRL_ACK && shift_q[0]) begin
                            state_d   = ST_RDATA;
                            shift_d   = rd_byte;
                            sda_low_d = ~rd_byte[7];
                        end else if (state_q == ST_CTRL_ACK) begin
                            state_d = ST_ADDR;
                        end else begin
                            state_d = ST_WDATA;
                        end
                    end
                end
                ST_RDATA: begin
                    if (scl_rise) begin
                        cnt_d = cnt_q + 4'd1;
                    end else if (scl_fall) begin
                        if (cnt_q == 4'd8) begin
                            state_d   = ST_RDATA_ACK;
                            cnt_d     = 4'd0;
                            sda_low_d = 1'b0;
                            ptr_d     = ptr_q + 1'b1;
                        end else begin
                            shift_d   = {shift_q[6:0], 1'b0};
                            sda_low_d = ~shift_q[6];
                        end
                    end
                end
                ST_RDATA_ACK: begin
                    if (scl_rise && sda_s == NACK) begin
                        state_d = ST_IDLE;
                    end else if (scl_fall) begin
                        state_d   = ST_RDATA;
                        shift_d   = rd_byte;
                        sda_low_d = ~rd_byte[7];
                    end
                end
                default: ;
            endcase
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 4'd0;
            shift_q    <= 8'd0;
            ptr_q      <= '0;
            sda_low_q  <= 1'b0;
            busy_q     <= 1'b0;
            wr_pulse_q <= 1'b0;
            wr_addr_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            ptr_q      <= ptr_d;
            sda_low_q  <= sda_low_d;
            busy_q     <= busy_d;
            wr_pulse_q <= wr_pulse_d;
            wr_addr_q  <= wr_addr_d;
        end
    end

    // Array contents survive reset.
    always_ff @(posedge CLK) begin
        if (RESET && mem_we)
            mem_q[ptr_q] <= shift_q;
    end

    // The only level this device ever drives is the ACK level (low).
    assign SDA       = sda_low_q ? ACK : 1'bz;
    assign BUSY      = busy_q;
    assign WR_PULSE  = wr_pulse_q;
    assign WR_ADDR   = wr_addr_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_eeprom_slave.sv
// tb_eeprom_slave: directed bench for eeprom_slave acting as the bus master.
module tb_eeprom_slave;
    import eeprom_pkg::*;

    // ---------------- clock / reset / bus ----------------
    logic   clk = 1'b0;
    logic   rst_n;
    logic   scl;
    logic   m_sda_low;
    wire    sda_bus;
    logic   busy, wr_pulse;
    logic [10:0] wr_addr;
    state_t dbg_state;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [10:0] exp_q[$];
    logic [10:0] obs_q[$];

    always #5 clk = ~clk;

    assign sda_bus = m_sda_low ? 1'b0 : 1'bz;
    pullup (sda_bus);

    eeprom_slave dut (
        .CLK       (clk),
        .RESET     (rst_n),
        .SCL       (scl),
        .SDA       (sda_bus),
        .BUSY      (busy),
        .WR_PULSE  (wr_pulse),
        .WR_ADDR   (wr_addr),
        .dbg_state (dbg_state)
    );

    always @(posedge clk) if (rst_n && wr_pulse) obs_q.push_back(wr_addr);

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog expired");
    end

    // ---------------- driver tasks ----------------
    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Entered 6 clk after an SCL fall; returns 6 clk after the next fall.
    task automatic xfer_bit(input logic b, output logic seen);
        m_sda_low = ~b;
        wait_clk(6);
        scl = 1'b1;
        wait_clk(4);
        seen = sda_bus;
        wait_clk(4);
        scl = 1'b0;
        wait_clk(6);
    endtask

    task automatic bus_start();
        m_sda_low = 1'b0;
        wait_clk(6);
        scl = 1'b1;
        wait_clk(6);
        m_sda_low = 1'b1;
        wait_clk(6);
        scl = 1'b0;
        wait_clk(6);
    endtask

    task automatic bus_stop();
        m_sda_low = 1'b1;
        wait_clk(6);
        scl = 1'b1;
        wait_clk(6);
        m_sda_low = 1'b0;
        wait_clk(6);
    endtask

    task automatic write_byte(input logic [7:0] b, output logic acked);
        logic s;
        for (int i = 7; i >= 0; i--) xfer_bit(b[i], s);
        xfer_bit(1'b1, s);
        acked = (s == 1'b0);
    endtask

    task automatic read_byte(input logic m_ack, output logic [7:0] d);
        logic s;
        d = 8'h00;
        for (int i = 0; i < 8; i++) begin
            xfer_bit(1'b1, s);
            d = {d[6:0], s};
        end
        xfer_bit(~m_ack, s);
    endtask

    task automatic set_ptr(input logic [10:0] a, output logic ok);
        logic a0, a1;
        bus_start();
        write_byte({4'hA, a[10:8], 1'b0}, a0);
        write_byte(a[7:0], a1);
        ok = a0 & a1;
    endtask

    task automatic do_read(input logic [10:0] a, output logic [7:0] d);
        logic ok, a0;
        set_ptr(a, ok);
        bus_start();
        write_byte(8'hA1, a0);
        read_byte(1'b0, d);
        bus_stop();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        wait_clk(4);
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b want 0", busy); end
        tests_run++; if (wr_pulse !== 1'b0) begin tests_failed++; $display("FAIL reset_wr_pulse: got %b want 0", wr_pulse); end
        tests_run++; if (wr_addr !== 11'h000) begin tests_failed++; $display("FAIL reset_wr_addr: got %h want 000", wr_addr); end
        tests_run++; if (sda_bus !== 1'b1) begin tests_failed++; $display("FAIL reset_sda: got %b want released", sda_bus); end
        tests_run++; if (dbg_state !== ST_IDLE) begin tests_failed++; $display("FAIL reset_state: got %0d want %0d", dbg_state, ST_IDLE); end
        rst_n = 1'b1;
        wait_clk(4);
    endtask

    task automatic test_write();
        logic a0, a1, a2;
        obs_q.delete();
        exp_q.delete();
        exp_q.push_back(11'h123);
        bus_start();
        write_byte(8'hA2, a0);
        write_byte(8'h23, a1);
        write_byte(8'h5A, a2);
        tests_run++; if ({a0, a1, a2} !== 3'b111) begin tests_failed++; $display("FAIL write_acks: got %b want 111", {a0, a1, a2}); end
        tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL write_busy: got %b want 1", busy); end
        bus_stop();
        wait_clk(8);
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL write_busy_after_stop: got %b want 0", busy); end
        tests_run++;
        if (obs_q.size() != exp_q.size()) begin
            tests_failed++; $display("FAIL write_pulses: got %0d want %0d", obs_q.size(), exp_q.size());
        end else begin
            foreach (exp_q[i]) if (obs_q[i] !== exp_q[i]) begin
                tests_failed++; $display("FAIL write_pulse_addr: got %h want %h", obs_q[i], exp_q[i]);
            end
        end
        tests_run++; if (wr_addr !== 11'h123) begin tests_failed++; $display("FAIL write_wr_addr: got %h want 123", wr_addr); end
    endtask

    task automatic test_random_read();
        logic ok, a0;
        logic [7:0] d;
        obs_q.delete();
        set_ptr(11'h123, ok);
        bus_start();
        write_byte(8'hA3, a0);
        read_byte(1'b0, d);
        tests_run++; if ({ok, a0} !== 2'b11) begin tests_failed++; $display("FAIL rread_acks: got %b want 11", {ok, a0}); end
        tests_run++; if (d !== 8'h5A) begin tests_failed++; $display("FAIL rread_data: got %h want 5a", d); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL rread_busy_after_nack: got %b want 0", busy); end
        tests_run++; if (dbg_state !== ST_IDLE) begin tests_failed++; $display("FAIL rread_state: got %0d want %0d", dbg_state, ST_IDLE); end
        bus_stop();
        wait_clk(4);
        tests_run++; if (obs_q.size() != 0) begin tests_failed++; $display("FAIL rread_no_write: got %0d pulses want 0", obs_q.size()); end
    endtask

    task automatic test_page_wrap();
        logic ok, a0, a1;
        logic [7:0] d0, d1;
        obs_q.delete();
        exp_q.delete();
        exp_q.push_back(11'h7FF);
        exp_q.push_back(11'h000);
        set_ptr(11'h7FF, ok);
        write_byte(8'hAA, a0);
        write_byte(8'hBB, a1);
        bus_stop();
        wait_clk(4);
        tests_run++; if ({ok, a0, a1} !== 3'b111) begin tests_failed++; $display("FAIL page_acks: got %b want 111", {ok, a0, a1}); end
        tests_run++;
        if (obs_q.size() != exp_q.size()) begin
            tests_failed++; $display("FAIL page_pulses: got %0d want %0d", obs_q.size(), exp_q.size());
        end else begin
            foreach (exp_q[i]) if (obs_q[i] !== exp_q[i]) begin
                tests_failed++; $display("FAIL page_pulse_addr: got %h want %h", obs_q[i], exp_q[i]);
            end
        end
        tests_run++; if (wr_addr !== 11'h000) begin tests_failed++; $display("FAIL page_wr_addr_wrap: got %h want 000", wr_addr); end
        set_ptr(11'h7FF, ok);
        bus_start();
        write_byte(8'hA1, a0);
        read_byte(1'b1, d0);
        read_byte(1'b0, d1);
        bus_stop();
        tests_run++; if (d0 !== 8'hAA) begin tests_failed++; $display("FAIL seq_read_7ff: got %h want aa", d0); end
        tests_run++; if (d1 !== 8'hBB) begin tests_failed++; $display("FAIL seq_read_000: got %h want bb", d1); end
    endtask

    task automatic test_bad_ctrl();
        logic a0, a1, a2;
        logic [7:0] d;
        obs_q.delete();
        bus_start();
        write_byte(8'hB0, a0);
        tests_run++; if (a0 !== 1'b0) begin tests_failed++; $display("FAIL badctrl_ack: got ack %b want 0", a0); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL badctrl_busy: got %b want 0", busy); end
        write_byte(8'h23, a1);
        write_byte(8'h77, a2);
        tests_run++; if ({a1, a2} !== 2'b00) begin tests_failed++; $display("FAIL badctrl_ignored_acks: got %b want 00", {a1, a2}); end
        bus_stop();
        wait_clk(4);
        tests_run++; if (obs_q.size() != 0) begin tests_failed++; $display("FAIL badctrl_no_write: got %0d pulses want 0", obs_q.size()); end
        do_read(11'h123, d);
        tests_run++; if (d !== 8'h5A) begin tests_failed++; $display("FAIL badctrl_array: got %h want 5a", d); end
    endtask

    task automatic test_partial_stop();
        logic ok, s;
        logic [7:0] d;
        obs_q.delete();
        set_ptr(11'h123, ok);
        for (int i = 0; i < 4; i++) xfer_bit(1'b1, s);
        bus_stop();
        wait_clk(4);
        tests_run++; if (obs_q.size() != 0) begin tests_failed++; $display("FAIL partial_no_write: got %0d pulses want 0", obs_q.size()); end
        tests_run++; if (dbg_state !== ST_IDLE) begin tests_failed++; $display("FAIL partial_state: got %0d want %0d", dbg_state, ST_IDLE); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL partial_busy: got %b want 0", busy); end
        do_read(11'h123, d);
        tests_run++; if (d !== 8'h5A) begin tests_failed++; $display("FAIL partial_array: got %h want 5a", d); end
    endtask

    task automatic test_reset_mid_read();
        logic ok, a0, a1;
        logic [7:0] d;
        set_ptr(11'h123, ok);
        bus_start();
        write_byte(8'hA3, a0);
        // bit 7 of 0x5A is 0, so the slave is pulling SDA low now
        tests_run++; if (sda_bus !== 1'b0) begin tests_failed++; $display("FAIL midread_driving: got %b want 0", sda_bus); end
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        tests_run++; if (sda_bus !== 1'b1) begin tests_failed++; $display("FAIL midread_release: got %b want released", sda_bus); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL midread_busy: got %b want 0", busy); end
        wait_clk(2);
        rst_n = 1'b1;
        wait_clk(4);
        obs_q.delete();
        set_ptr(11'h010, ok);
        write_byte(8'h3C, a1);
        bus_stop();
        wait_clk(4);
        tests_run++; if ({ok, a1} !== 2'b11) begin tests_failed++; $display("FAIL postreset_acks: got %b want 11", {ok, a1}); end
        tests_run++; if (obs_q.size() != 1) begin tests_failed++; $display("FAIL postreset_pulses: got %0d want 1", obs_q.size()); end
        tests_run++; if (wr_addr !== 11'h010) begin tests_failed++; $display("FAIL postreset_wr_addr: got %h want 010", wr_addr); end
        do_read(11'h010, d);
        tests_run++; if (d !== 8'h3C) begin tests_failed++; $display("FAIL postreset_read: got %h want 3c", d); end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        rst_n     = 1'b0;
        scl       = 1'b1;
        m_sda_low = 1'b0;
        test_reset();
        test_write();
        test_random_read();
        test_page_wrap();
        test_bad_ctrl();
        test_partial_stop();
        test_reset_mid_read();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
